rr_select_encoder: RTL and testbench
====================================

// Module: rr_select_encoder
// PURPOSE
//  Round-robin request arbiter that feeds the 2-to-4 decoder stage.
//  - Four request lines in; registered 2-bit channel index (sel) out, which drives the decoder's input_data.
//  - Each grant is held for a programmable dwell time.
//  - Consecutive grants are separated by an idle gap (sel_valid low), giving break-before-make.
//  - Downstream one-hot enables = decoder(sel) & {4{sel_valid}}.
// PARAMETERS
//  DWELL_CYCLES  4  cycles sel_valid stays high per grant; legal range 1..255
//  CNT_W         8  dwell counter width; must satisfy 2**CNT_W > DWELL_CYCLES
// PORTS
//  clk         in   1  system clock, all state updates on rising edge
//  rst_n       in   1  asynchronous active-low reset
//  en          in   1  arbiter enable; low aborts any grant in progress
//  req         in   4  level request per channel, bit i = channel i
//  release_i   in   1  early-release of the current grant
//  sel         out  2  granted channel index (decoder input_data)
//  sel_valid   out  1  sel is a live grant
//  grant_done  out  1  one-cycle pulse on normal grant completion
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, sel=2'b00, sel_valid=0, grant_done=0, cnt=0.
//   - Last-grant pointer ptr=2'b11, so channel 0 has first priority.
//  Outputs: all registered, no combinational path from inputs to outputs.
//  FSM states: IDLE, GRANT, GAP.
//  IDLE:
//   - If en && |req at edge N: sel <= first set req bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
//   - Same edge: sel_valid <= 1, cnt <= DWELL_CYCLES-1, state <= GRANT.
//   - Latency: sel/sel_valid visible one cycle after req is sampled.
//   - Otherwise remain in IDLE with all outputs held.
//  GRANT (checked in priority order at each edge):
//   - !en: abort. sel_valid <= 0, state <= IDLE, no grant_done, ptr unchanged.
//   - cnt==0 || release_i: completion.
//     - sel_valid <= 0, grant_done <= 1 for one cycle, ptr <= sel, state <= GAP.
//   - Else: cnt <= cnt-1. sel stays stable for the whole grant.
//   - req is not re-sampled during GRANT; a dropped request still runs to completion.
//  GAP:
//   - Single cycle with sel_valid=0; sel keeps the last value.
//   - state <= IDLE unconditionally.
//  Cadence: back-to-back grants show exactly DWELL_CYCLES high, then 2 low (GAP + IDLE decision).
//  Boundaries:
//   - DWELL_CYCLES=1: sel_valid is high for exactly 1 cycle.
//   - release_i and cnt==0 together: a single grant_done.
//   - release_i on the first grant cycle: sel_valid is high for 1 cycle.
//   - en low together with release_i: abort wins, no grant_done.
//   - ptr wraps 3 -> 0.
//   - req=0 in IDLE: no grant. Requests with en=0 are ignored.
//   - rst_n asserted mid-grant: outputs clear immediately, no grant_done.
//  grant_done never overlaps sel_valid=1 of the same grant.
// TESTING
//  1 Reset: rst_n=0 at any state -> sel=0, sel_valid=0, grant_done=0 immediately, without waiting for a clock edge.
//  2 Single channel: en=1, req=4'b0001, DWELL=4 -> sel=0 with valid 4 cycles; grant_done 1 cycle as valid falls; 2 low cycles; repeat.
//  3 Fairness: req=4'b1111 held -> sel sequence 0,1,2,3,0 on successive grants.
//  4 Wrap/skip: after granting ch3, req=4'b1010 -> next grant ch1, then ch3, then ch1.
//  5 Early release: release_i=1 in 2nd grant cycle -> valid 2 cycles, exactly one grant_done.
//  6 Abort: en=0 in 3rd grant cycle of ch2 -> valid falls next edge, no grant_done; en=1 again with req=4'b0100 -> ch2 re-granted.

Source files
------------

// File: rtl/rr_select_encoder.sv
// ============================================================================
// Module   : rr_select_encoder
// Purpose  : Round-robin arbiter with registered channel index, dwell timing
//            and a break-before-make gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select_encoder #(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       release_i,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       grant_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [CNT_W-1:0] c_dwell_load = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic [1:0]       w_sel_nxt;
  logic             w_valid_nxt;
  logic             w_done_nxt;
  logic [1:0]       w_pick;
  logic             w_any_req;
  logic             w_complete;

  assign w_any_req  = |req;
  assign w_complete = (r_cnt == '0) || release_i;

  // Walk from the lowest-priority slot upward so the nearest hit after ptr wins.
  always_comb begin
    w_pick = 2'b00;
    for (int k = 4; k >= 1; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_pick = r_ptr + 2'(k);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ptr      <= 2'b11;
      sel        <= 2'b00;
      sel_valid  <= 1'b0;
      grant_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      sel        <= w_sel_nxt;
      sel_valid  <= w_valid_nxt;
      grant_done <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (en && w_any_req) begin
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_complete) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values; abort outranks completion in GRANT.
  always_comb begin
    w_sel_nxt   = sel;
    w_valid_nxt = sel_valid;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (en && w_any_req) begin
          w_sel_nxt   = w_pick;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = c_dwell_load;
        end
      end
      ST_GRANT: begin
        if (!en) begin
          w_valid_nxt = 1'b0;
        end else if (w_complete) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_ptr_nxt   = sel;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_select_encoder.sv
// ============================================================================
// Module   : tb_rr_select_encoder
// Purpose  : Self-checking bench for rr_select_encoder (dwell 4 and dwell 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_select_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       release_i = 1'b0;

  logic [1:0] sel4, sel1;
  logic       sel_valid4, sel_valid1;
  logic       grant_done4, grant_done1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_select_encoder #(.DWELL_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .release_i(release_i),
    .sel(sel4), .sel_valid(sel_valid4), .grant_done(grant_done4)
  );

  rr_select_encoder #(.DWELL_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .release_i(release_i),
    .sel(sel1), .sel_valid(sel_valid1), .grant_done(grant_done1)
  );

  // Reference: 'age' is how many cycles the current grant has been visible,
  // 'cool' marks the mandatory dead cycle after a completed grant.
  typedef struct {
    int sel;
    int valid;
    int done;
    int last;
    int age;
    int cool;
  } model_t;

  model_t m4, m1;
  int     grant_log[$];
  int     vcnt4, dcnt4;
  logic   prev_v4;

  function automatic model_t model_reset();
    model_t m;
    m.sel = 0; m.valid = 0; m.done = 0; m.last = 3; m.age = 0; m.cool = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int dwell, logic e, logic [3:0] r, logic rl);
    model_t n;
    n = m;
    n.done = 0;
    if (m.valid != 0) begin
      if (!e) begin
        n.valid = 0;
      end else if (m.age >= dwell || rl) begin
        n.valid = 0;
        n.done  = 1;
        n.last  = m.sel;
        n.cool  = 1;
      end else begin
        n.age = m.age + 1;
      end
    end else if (m.cool != 0) begin
      n.cool = 0;
    end else if (e && r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        int ch;
        ch = (m.last + k) % 4;
        if (r[ch] && n.valid == 0) begin
          n.sel   = ch;
          n.valid = 1;
          n.age   = 1;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("sel4",   int'(sel4),        m4.sel);
    check("valid4", int'(sel_valid4),  m4.valid);
    check("done4",  int'(grant_done4), m4.done);
    check("sel1",   int'(sel1),        m1.sel);
    check("valid1", int'(sel_valid1),  m1.valid);
    check("done1",  int'(grant_done1), m1.done);
  endtask

  // Called at a falling edge: drive, advance model, sample at next falling edge.
  task automatic cycle(input logic e, input logic [3:0] r, input logic rl);
    en = e; req = r; release_i = rl;
    m4 = model_step(m4, 4, e, r, rl);
    m1 = model_step(m1, 1, e, r, rl);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (sel_valid4 && !prev_v4) grant_log.push_back(int'(sel4));
    if (sel_valid4) vcnt4++;
    if (grant_done4) dcnt4++;
    prev_v4 = sel_valid4;
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    en = 1'b0; req = 4'b0000; release_i = 1'b0;
    rst_n = 1'b0;
    #1;
    m4 = model_reset();
    m1 = model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    prev_v4 = 1'b0;
    grant_log.delete();
    vcnt4 = 0;
    dcnt4 = 0;
  endtask

  task automatic check_log(input string tag, input int exp[]);
    check({tag, "_len"}, grant_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++) begin
      check(tag, grant_log[i], exp[i]);
    end
  endtask

  initial begin
    m4 = model_reset();
    m1 = model_reset();
    prev_v4 = 1'b0;
    @(negedge clk);
    do_reset();

    // Single channel, repeated grants
    for (int i = 0; i < 12; i++) cycle(1'b1, 4'b0001, 1'b0);
    check("single_valid_cycles", vcnt4, 8);
    check("single_done_pulses", dcnt4, 2);
    check_log("single_seq", '{0, 0});

    // Fairness with all requests held
    do_reset();
    for (int i = 0; i < 26; i++) cycle(1'b1, 4'b1111, 1'b0);
    check_log("fair_seq", '{0, 1, 2, 3, 0});

    // Wrap and skip after channel 3
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'b1000, 1'b0);
    for (int i = 0; i < 18; i++) cycle(1'b1, 4'b1010, 1'b0);
    check_log("wrap_seq", '{3, 1, 3, 1});

    // Early release in the second grant cycle
    do_reset();
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b1, 4'b0001, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0000, 1'b0);
    check("early_valid_cycles", vcnt4, 2);
    check("early_done_pulses", dcnt4, 1);

    // Abort in the third grant cycle of ch2 (release asserted too), then re-grant
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0100, 1'b1);
    cycle(1'b1, 4'b0100, 1'b0);
    check("abort_done_pulses", dcnt4, 0);
    check("abort_valid_cycles", vcnt4, 4);
    check_log("abort_seq", '{2, 2});
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'b0100, 1'b0);

    // Requests ignored while disabled, none granted with req=0
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0000, 1'b0);
    check("idle_valid_cycles", vcnt4, 0);

    // Reset mid-grant
    do_reset();
    cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0);
    do_reset();
    cycle(1'b0, 4'b0000, 1'b0);

    // Randomized traffic with occasional async resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
